// File: rtl/regfile_writeback_arbiter_pkg.sv
// Shared definitions for the register file writeback arbiter slice:
// default widths and the channel encoding used by the round-robin state.
package regfile_writeback_arbiter_pkg;

  localparam int ADDR_WIDTH_DEF = 5;
  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic {
    CH_EXU = 1'b0,
    CH_LSU = 1'b1
  } channel_e;

endpackage

// File: rtl/regfile_writeback_arbiter_wb_scoreboard.sv
// Busy-bit scoreboard of in-flight destination registers; drives the source
// probes used for RAW stalls and the issue_ready used for WAW stalls.
module regfile_writeback_arbiter_wb_scoreboard
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic                  clr_valid,
  input  logic [ADDR_WIDTH-1:0] clr_rd,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic                  rs1_busy,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs2_busy
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  assign issue_ready = issue_valid ? !busy_q[issue_rd] : 1'b1;
  assign rs1_busy    = busy_q[rs1_addr];
  assign rs2_busy    = busy_q[rs2_addr];

  // Set needs !busy, so a set and clear never hit the same index together.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid) begin
      busy_d[clr_rd] = 1'b0;
    end
    if (issue_valid && issue_ready && (issue_rd != '0)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Write side of the integer register file: round-robin arbitration between
// EXU and LSU results, a registered write port and the destination scoreboard.
module regfile_writeback_arbiter
  import regfile_writeback_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic                  exu_wen,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic                  lsu_wen,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_ready,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic                  rs1_busy,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic                  rs2_busy,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  commit_valid
);

  channel_e              last_grant_q, last_grant_d;
  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic                  commit_valid_q, commit_valid_d;

  logic                  exu_gnt, lsu_gnt, any_gnt;
  logic [ADDR_WIDTH-1:0] win_rd;
  logic                  win_wen;
  logic [DATA_WIDTH-1:0] win_data;

  // On contention the channel that did not win last time gets the slot.
  always_comb begin
    exu_gnt = exu_valid && (!lsu_valid || (last_grant_q == CH_LSU));
    lsu_gnt = lsu_valid && (!exu_valid || (last_grant_q == CH_EXU));
    any_gnt = exu_gnt || lsu_gnt;

    win_rd   = lsu_gnt ? lsu_rd   : exu_rd;
    win_wen  = lsu_gnt ? lsu_wen  : exu_wen;
    win_data = lsu_gnt ? lsu_data : exu_data;

    last_grant_d = last_grant_q;
    if (lsu_gnt) begin
      last_grant_d = CH_LSU;
    end else if (exu_gnt) begin
      last_grant_d = CH_EXU;
    end

    rf_wen_d       = any_gnt && win_wen && (win_rd != '0);
    commit_valid_d = any_gnt;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    if (any_gnt) begin
      rf_waddr_d = win_rd;
      rf_wdata_d = win_data;
    end
  end

  assign exu_ready    = exu_gnt;
  assign lsu_ready    = lsu_gnt;
  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign commit_valid = commit_valid_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q   <= CH_EXU;
      rf_wen_q       <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
      commit_valid_q <= 1'b0;
    end else begin
      last_grant_q   <= last_grant_d;
      rf_wen_q       <= rf_wen_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
      commit_valid_q <= commit_valid_d;
    end
  end

  // Busy clears at the grant edge; non-writing results leave it untouched.
  regfile_writeback_arbiter_wb_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .clk        (clk),
    .rstn       (rstn),
    .issue_valid(issue_valid),
    .issue_rd   (issue_rd),
    .issue_ready(issue_ready),
    .clr_valid  (any_gnt && win_wen),
    .clr_rd     (win_rd),
    .rs1_addr   (rs1_addr),
    .rs1_busy   (rs1_busy),
    .rs2_addr   (rs2_addr),
    .rs2_busy   (rs2_busy)
  );

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Self-checking bench for regfile_writeback_arbiter: table-driven vectors with
// a write-port scoreboard queue, plus a hand-written mid-stream reset sequence.
module tb_regfile_writeback_arbiter;

  logic        clk;
  logic        rstn;
  logic        exu_valid, exu_ready, exu_wen;
  logic [4:0]  exu_rd;
  logic [31:0] exu_data;
  logic        lsu_valid, lsu_ready, lsu_wen;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_addr, rs2_addr;
  logic        rs1_busy, rs2_busy;
  logic        rf_wen, commit_valid;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  regfile_writeback_arbiter dut (
    .clk         (clk),
    .rstn        (rstn),
    .exu_valid   (exu_valid),
    .exu_ready   (exu_ready),
    .exu_rd      (exu_rd),
    .exu_wen     (exu_wen),
    .exu_data    (exu_data),
    .lsu_valid   (lsu_valid),
    .lsu_ready   (lsu_ready),
    .lsu_rd      (lsu_rd),
    .lsu_wen     (lsu_wen),
    .lsu_data    (lsu_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs1_addr    (rs1_addr),
    .rs1_busy    (rs1_busy),
    .rs2_addr    (rs2_addr),
    .rs2_busy    (rs2_busy),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .commit_valid(commit_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ev;
    logic [4:0]  erd;
    logic        ewen;
    logic [31:0] edata;
    logic        lv;
    logic [4:0]  lrd;
    logic        lwen;
    logic [31:0] ldata;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        xer;
    logic        xlr;
    logic        xir;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        commit;
  } wr_t;

  vec_t        vecs[21];
  wr_t         expQ[$];
  logic [31:0] modelBusy;
  logic [4:0]  expAddr;
  logic [31:0] expData;
  int          checks = 0;
  int          passes = 0;

  function automatic vec_t mk(input logic ev, input logic [4:0] erd, input logic ewen,
                              input logic [31:0] edata, input logic lv, input logic [4:0] lrd,
                              input logic lwen, input logic [31:0] ldata, input logic iv,
                              input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2,
                              input logic xer, input logic xlr, input logic xir);
    vec_t v;
    v.ev = ev; v.erd = erd; v.ewen = ewen; v.edata = edata;
    v.lv = lv; v.lrd = lrd; v.lwen = lwen; v.ldata = ldata;
    v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
    v.xer = xer; v.xlr = xlr; v.xir = xir;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idleInputs();
    exu_valid = 0; exu_rd = 0; exu_wen = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_wen = 0; lsu_data = 0;
    issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
  endtask

  task automatic resetModel();
    modelBusy = '0;
    expAddr   = '0;
    expData   = '0;
    expQ.delete();
  endtask

  // One cycle: drive, check combinational outputs, push expected write, check after edge.
  task automatic applyStimulus(input int idx);
    vec_t v;
    wr_t  w, got;
    v = vecs[idx];
    @(negedge clk);
    exu_valid = v.ev; exu_rd = v.erd; exu_wen = v.ewen; exu_data = v.edata;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_wen = v.lwen; lsu_data = v.ldata;
    issue_valid = v.iv; issue_rd = v.ird; rs1_addr = v.r1; rs2_addr = v.r2;
    #1;
    checkOutput($sformatf("v%0d exu_ready", idx), {31'b0, exu_ready}, {31'b0, v.xer});
    checkOutput($sformatf("v%0d lsu_ready", idx), {31'b0, lsu_ready}, {31'b0, v.xlr});
    checkOutput($sformatf("v%0d issue_ready", idx), {31'b0, issue_ready}, {31'b0, v.xir});
    checkOutput($sformatf("v%0d rs1_busy", idx), {31'b0, rs1_busy}, {31'b0, modelBusy[v.r1]});
    checkOutput($sformatf("v%0d rs2_busy", idx), {31'b0, rs2_busy}, {31'b0, modelBusy[v.r2]});

    w.commit = v.xer | v.xlr;
    w.wen    = 1'b0;
    if (v.xer) begin
      w.wen = v.ewen && (v.erd != 0); expAddr = v.erd; expData = v.edata;
      if (v.ewen) modelBusy[v.erd] = 1'b0;
    end else if (v.xlr) begin
      w.wen = v.lwen && (v.lrd != 0); expAddr = v.lrd; expData = v.ldata;
      if (v.lwen) modelBusy[v.lrd] = 1'b0;
    end
    w.addr = expAddr;
    w.data = expData;
    if (v.iv && v.xir && (v.ird != 0)) modelBusy[v.ird] = 1'b1;
    expQ.push_back(w);

    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput($sformatf("v%0d queue_empty", idx), 32'd1, 32'd0);
    end else begin
      got = expQ.pop_front();
      checkOutput($sformatf("v%0d rf_wen", idx), {31'b0, rf_wen}, {31'b0, got.wen});
      checkOutput($sformatf("v%0d rf_waddr", idx), {27'b0, rf_waddr}, {27'b0, got.addr});
      checkOutput($sformatf("v%0d rf_wdata", idx), rf_wdata, got.data);
      checkOutput($sformatf("v%0d commit_valid", idx), {31'b0, commit_valid}, {31'b0, got.commit});
    end
  endtask

  initial begin
    vecs[0]  = mk(1, 3, 1, 32'hDEADBEEF, 0, 0, 0, 0,           0, 0,  3, 0,  1, 0, 1);
    vecs[1]  = mk(1, 10, 1, 32'hA1,      1, 11, 1, 32'hB1,     0, 0,  0, 0,  0, 1, 1);
    vecs[2]  = mk(1, 10, 1, 32'hA1,      1, 12, 1, 32'hB2,     0, 0,  0, 0,  1, 0, 1);
    vecs[3]  = mk(1, 13, 1, 32'hA2,      1, 12, 1, 32'hB2,     0, 0,  0, 0,  0, 1, 1);
    vecs[4]  = mk(1, 13, 1, 32'hA2,      1, 14, 1, 32'hB3,     0, 0,  0, 0,  1, 0, 1);
    vecs[5]  = mk(0, 0, 0, 0,            1, 14, 1, 32'hB3,     0, 0,  0, 0,  0, 1, 1);
    vecs[6]  = mk(0, 0, 0, 0,            0, 0, 0, 0,           1, 7,  7, 0,  0, 0, 1);
    vecs[7]  = mk(0, 0, 0, 0,            1, 7, 1, 32'h77,      1, 7,  7, 0,  0, 1, 0);
    vecs[8]  = mk(0, 0, 0, 0,            0, 0, 0, 0,           1, 7,  7, 0,  0, 0, 1);
    vecs[9]  = mk(1, 0, 1, 32'h1234,     0, 0, 0, 0,           1, 0,  0, 0,  1, 0, 1);
    vecs[10] = mk(0, 0, 0, 0,            0, 0, 0, 0,           1, 9,  0, 9,  0, 0, 1);
    vecs[11] = mk(0, 0, 0, 0,            0, 0, 0, 0,           0, 0,  0, 9,  0, 0, 1);
    vecs[12] = mk(1, 9, 1, 32'h99,       0, 0, 0, 0,           0, 0,  0, 9,  1, 0, 1);
    vecs[13] = mk(0, 0, 0, 0,            0, 0, 0, 0,           0, 0,  0, 9,  0, 0, 1);
    vecs[14] = mk(0, 0, 0, 0,            1, 7, 1, 32'h7777,    1, 20, 7, 20, 0, 1, 1);
    vecs[15] = mk(0, 0, 0, 0,            0, 0, 0, 0,           0, 0,  7, 20, 0, 0, 1);
    vecs[16] = mk(1, 20, 0, 32'h55,      0, 0, 0, 0,           0, 0,  0, 20, 1, 0, 1);
    vecs[17] = mk(0, 0, 0, 0,            0, 0, 0, 0,           0, 0,  0, 20, 0, 0, 1);
    vecs[18] = mk(0, 0, 0, 0,            1, 2, 1, 32'h2222,    1, 5,  0, 5,  0, 1, 1);
    vecs[19] = mk(1, 1, 1, 32'h111,      1, 2, 1, 32'h222,     0, 0, 20, 5,  0, 1, 1);
    vecs[20] = mk(1, 1, 1, 32'h111,      0, 0, 0, 0,           0, 0, 20, 5,  1, 0, 1);

    idleInputs();
    resetModel();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset rf_wen", {31'b0, rf_wen}, 32'd0);
    checkOutput("reset rf_waddr", {27'b0, rf_waddr}, 32'd0);
    checkOutput("reset rf_wdata", rf_wdata, 32'd0);
    checkOutput("reset commit_valid", {31'b0, commit_valid}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i <= 18; i++) applyStimulus(i);

    // Reset lands between an accepted EXU result and the edge that would load it.
    @(negedge clk);
    exu_valid = 1; exu_rd = 5; exu_wen = 1; exu_data = 32'h5555;
    lsu_valid = 0; issue_valid = 0; rs1_addr = 5; rs2_addr = 20;
    #1;
    checkOutput("midrst exu_ready", {31'b0, exu_ready}, 32'd1);
    checkOutput("midrst busy5 before", {31'b0, rs1_busy}, 32'd1);
    rstn = 1'b0;
    #1;
    checkOutput("midrst busy5 cleared", {31'b0, rs1_busy}, 32'd0);
    checkOutput("midrst busy20 cleared", {31'b0, rs2_busy}, 32'd0);
    checkOutput("midrst rf_wen async", {31'b0, rf_wen}, 32'd0);
    @(posedge clk);
    #1;
    checkOutput("midrst rf_wen", {31'b0, rf_wen}, 32'd0);
    checkOutput("midrst commit_valid", {31'b0, commit_valid}, 32'd0);
    checkOutput("midrst rf_waddr", {27'b0, rf_waddr}, 32'd0);
    checkOutput("midrst rf_wdata", rf_wdata, 32'd0);
    @(negedge clk);
    idleInputs();
    resetModel();
    rstn = 1'b1;

    for (int i = 19; i <= 20; i++) applyStimulus(i);

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
